board_reset_conditioner: RTL

Board-level reset conditioner that sits directly upstream of the SoC reset input on FPGA board tops. It takes a raw push-button and:
- synchronizes and debounces it with a counter;
- runs a small FSM that holds the SoC reset asserted while the button is pressed, plus a fixed stretch after release;
- issues a clean, glitch-free reset to the core, deasserted synchronously to the clock.

---
 rtl/rvsteel_reset_pkg.sv | 21 ++
 rtl/button_debouncer.sv | 71 +++++++
 rtl/board_reset_conditioner.sv | 123 ++++++++++++
 3 files changed

// File: rtl/rvsteel_reset_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rvsteel_reset_pkg
// Brief   : Shared FSM encodings and counter sizing for the reset conditioner.
// Revision: 1.0 - initial release
// ============================================================================
package rvsteel_reset_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RUN     = 2'd1,
    PRESSED = 2'd2
  } rst_state_e;

  // Bits needed to hold 0..n inclusive; never less than one bit.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module  : button_debouncer
// Brief   : Two-flop synchronizer, polarity normalize and counter debounce.
// Revision: 1.0 - initial release
// ============================================================================
module button_debouncer
  import rvsteel_reset_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES    = 500000,
  parameter bit BUTTON_ACTIVE_HIGH = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic button_level,
  output logic button_pressed,
  output logic stable
);

  localparam int            DW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES);
  localparam logic          IDLE_RAW = !BUTTON_ACTIVE_HIGH;

  logic [1:0]    sync_q, sync_d;
  logic          sample;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic          level_q, level_d;
  logic          level_dly_q;
  logic          pressed_q, pressed_d;

  always_comb begin
    sync_d    = {sync_q[0], button};
    sample    = BUTTON_ACTIVE_HIGH ? sync_q[1] : ~sync_q[1];
    deb_cnt_d = deb_cnt_q;
    level_d   = level_q;
    if (sample == level_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_LAST) begin
      level_d   = ~level_q;
      deb_cnt_d = '0;
    end else if (deb_cnt_q != DEB_MAX) begin
      deb_cnt_d = deb_cnt_q + DW'(1);
    end
    // Pulse one cycle after the debounced level rises.
    pressed_d = level_q & ~level_dly_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q      <= {2{IDLE_RAW}};
      deb_cnt_q   <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      pressed_q   <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      deb_cnt_q   <= deb_cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
      pressed_q   <= pressed_d;
    end
  end

  assign button_level   = level_q;
  assign button_pressed = pressed_q;
  assign stable         = (deb_cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/board_reset_conditioner.sv
`default_nettype none
// ============================================================================
// Module  : board_reset_conditioner
// Brief   : Push-button reset conditioner with release stretch; optional
//           power-on hold selected by RESET_CONDITIONER_POR_EN.
// Revision: 1.0 - initial release
// ============================================================================
module board_reset_conditioner
  import rvsteel_reset_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES    = 500000,
  parameter int STRETCH_CYCLES     = 1024,
  parameter bit BUTTON_ACTIVE_HIGH = 1'b1,
  parameter int POR_CYCLES         = 65536
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic reset_out,
  output logic button_level,
  output logic button_pressed
);

  localparam int            SW       = cnt_width(STRETCH_CYCLES);
  localparam logic [SW-1:0] STR_LAST = SW'(STRETCH_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || STRETCH_CYCLES < 1 || POR_CYCLES < 1) begin : g_param_check
    $error("board_reset_conditioner: cycle parameters must be >= 1");
  end

  rst_state_e    state_q, state_d;
  logic [SW-1:0] str_cnt_q, str_cnt_d;
  logic          level_seen_q;
  logic          stable;
  logic          fsm_reset_d;
  logic          reset_out_d;
  logic          reset_out_q;

  button_debouncer #(
    .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
    .BUTTON_ACTIVE_HIGH (BUTTON_ACTIVE_HIGH)
  ) u_debouncer (
    .clock          (clock),
    .reset          (reset),
    .button         (button),
    .button_level   (button_level),
    .button_pressed (button_pressed),
    .stable         (stable)
  );

  always_comb begin
    state_d   = state_q;
    str_cnt_d = str_cnt_q;
    case (state_q)
      HOLD: begin
        // Clearing for one extra cycle after a release inside HOLD gives the
        // same release-to-deassert delay as the PRESSED->HOLD path.
        if (button_level || level_seen_q) begin
          str_cnt_d = '0;
        end else if (str_cnt_q == STR_LAST && stable) begin
          state_d   = RUN;
          str_cnt_d = '0;
        end else if (str_cnt_q != STR_LAST) begin
          str_cnt_d = str_cnt_q + SW'(1);
        end
      end
      RUN: begin
        str_cnt_d = '0;
        if (button_level) state_d = PRESSED;
      end
      PRESSED: begin
        str_cnt_d = '0;
        if (!button_level) state_d = HOLD;
      end
      default: begin
        state_d   = HOLD;
        str_cnt_d = '0;
      end
    endcase
    fsm_reset_d = (state_d != RUN);
  end

`ifdef RESET_CONDITIONER_POR_EN
  localparam int            PW       = cnt_width(POR_CYCLES);
  localparam logic [PW-1:0] POR_LAST = PW'(POR_CYCLES - 1);

  // Power-up value only; the reset port deliberately does not clear it.
  logic [PW-1:0] por_cnt_q = '0;
  logic [PW-1:0] por_cnt_d;
  logic          por_done;

  always_comb begin
    por_done  = (por_cnt_q == POR_LAST);
    por_cnt_d = por_done ? por_cnt_q : por_cnt_q + PW'(1);
  end

  always_ff @(posedge clock) begin
    por_cnt_q <= por_cnt_d;
  end

  assign reset_out_d = fsm_reset_d | ~por_done;
`else
  assign reset_out_d = fsm_reset_d;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= HOLD;
      str_cnt_q    <= '0;
      level_seen_q <= 1'b0;
      reset_out_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      str_cnt_q    <= str_cnt_d;
      level_seen_q <= button_level;
      reset_out_q  <= reset_out_d;
    end
  end

  assign reset_out = reset_out_q;

endmodule
`default_nettype wire
